regfile_access_ctrl: RTL and testbench

//  Initiator side of the register-file port: drives read address, write enable, write register and write data; captures read data.

---
 rtl/regfile_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: queues writebacks in a small FIFO and serialises them
// with operand reads through one FSM so reads always observe program-order writes.
module regfile_access_ctrl #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int WQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_reg1,
    input  logic [AW-1:0] rd_reg2,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data1,
    output logic [DW-1:0] rsp_data2,
    output logic [AW-1:0] rf_rreg1,
    output logic [AW-1:0] rf_rreg2,
    output logic          rf_enwr,
    output logic [AW-1:0] rf_regnum,
    output logic [DW-1:0] rf_wrdata,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          busy
);

    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_END,
        S_RD_ADDR,
        S_RD_CAP,
        S_RSP
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] fifo_reg  [WQ_DEPTH];
    logic [DW-1:0] fifo_data [WQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, push, pop;
    logic          rd_fire;
    logic [AW-1:0] rd_reg1_q, rd_reg2_q;

    assign empty    = (count == '0);
    assign full     = (count == CW'(WQ_DEPTH));
    assign wb_ready = !full;
    assign rd_ready = (state == S_IDLE) && empty;
    assign rd_fire  = rd_valid && rd_ready;
    // Writes to register 0 complete the handshake but never reach the file.
    assign push     = wb_valid && !full && (wb_reg != '0);
    assign pop      = (state == S_WR);
    assign busy     = (state != S_IDLE) || !empty;

    assign rf_enwr   = (state == S_WR);
    assign rsp_valid = (state == S_RSP);
    // Addresses fall back to 0 outside a read so every read shows a fresh address.
    assign rf_rreg1  = (state == S_RD_ADDR || state == S_RD_CAP) ? rd_reg1_q : '0;
    assign rf_rreg2  = (state == S_RD_ADDR || state == S_RD_CAP) ? rd_reg2_q : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= wb_reg;
            fifo_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!empty)       state_next = S_WR;
                else if (rd_fire) state_next = S_RD_ADDR;
            end
            S_WR:      state_next = S_WR_END;
            S_WR_END:  state_next = S_IDLE;
            S_RD_ADDR: state_next = S_RD_CAP;
            S_RD_CAP:  state_next = S_RSP;
            S_RSP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Write port and read latches: loaded on the IDLE decision, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_regnum <= '0;
            rf_wrdata <= '0;
            rd_reg1_q <= '0;
            rd_reg2_q <= '0;
        end else if (state == S_IDLE) begin
            if (!empty) begin
                rf_regnum <= fifo_reg[rd_ptr];
                rf_wrdata <= fifo_data[rd_ptr];
            end else if (rd_fire) begin
                rd_reg1_q <= rd_reg1;
                rd_reg2_q <= rd_reg2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else if (state == S_RD_CAP) begin
            rsp_data1 <= (rd_reg1_q == '0) ? '0 : rf_rdata1;
            rsp_data2 <= (rd_reg2_q == '0) ? '0 : rf_rdata2;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a synchronous-read register file model.
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_reg1, rd_reg2;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data1, rsp_data2;
    logic [AW-1:0] rf_rreg1, rf_rreg2;
    logic          rf_enwr;
    logic [AW-1:0] rf_regnum;
    logic [DW-1:0] rf_wrdata;
    logic [DW-1:0] rf_rdata1, rf_rdata2;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DW(DW), .AW(AW), .WQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_rreg1(rf_rreg1), .rf_rreg2(rf_rreg2), .rf_enwr(rf_enwr),
        .rf_regnum(rf_regnum), .rf_wrdata(rf_wrdata),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .busy(busy)
    );

    // Register file model; entry 0 holds junk so the zero forcing is observable.
    logic [DW-1:0] mem [32];
    logic          mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[0] <= 32'hBAD0_BAD0;
            mem_init_done <= 1'b1;
        end else if (rf_enwr && rf_regnum != '0) begin
            mem[rf_regnum] <= rf_wrdata;
        end
        rf_rdata1 <= mem[rf_rreg1];
        rf_rdata2 <= mem[rf_rreg2];
    end

    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_reg = '0;
    always @(negedge clk) begin
        if (rf_enwr) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_reg <= rf_regnum;
        end
    end

    typedef struct {
        logic [AW-1:0] wreg;
        logic [DW-1:0] wdata;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] r, input logic [DW-1:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
        while (!wb_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("wb_ready_wait", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        $display("write r%0d = %h", r, d);
    endtask

    // Called #1 after the read handshake edge; waits for and checks the response.
    task automatic finish_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        int lat = 0;
        chk("rf_rreg1", 64'(rf_rreg1), 64'(r1));
        chk("rf_rreg2", 64'(rf_rreg2), 64'(r2));
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("rsp_latency", 64'(lat), 64'd2);
        chk("rsp_data1", 64'(rsp_data1), 64'(e1));
        chk("rsp_data2", 64'(rsp_data2), 64'(e2));
        $display("read (%0d,%0d) -> %h %h", r1, r2, rsp_data1, rsp_data2);
        @(posedge clk); #1;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("rf_rreg1_idle", 64'(rf_rreg1), 64'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        int n = 0;
        rsp_ready = 1'b1;
        rd_valid = 1'b1; rd_reg1 = r1; rd_reg2 = r2;
        while (!rd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rd_ready_wait", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        finish_read(r1, r2, e1, e2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        vecs[0] = '{5'd5,  32'hDEAD_BEEF, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{5'd7,  32'h1234_5678, 5'd7,  5'd5,  32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{5'd31, 32'hA5A5_A5A5, 5'd31, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[3] = '{5'd5,  32'h0000_0001, 5'd5,  5'd7,  32'h0000_0001, 32'h1234_5678};
        vecs[4] = '{5'd0,  32'h0000_FFFF, 5'd0,  5'd5,  32'h0,         32'h0000_0001};

        rst_n = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        rd_valid = 1'b0; rd_reg1 = '0; rd_reg2 = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rf_enwr", 64'(rf_enwr), 64'd0);
        chk("rst_rf_regnum", 64'(rf_regnum), 64'd0);
        chk("rst_rf_wrdata", 64'(rf_wrdata), 64'd0);
        chk("rst_rf_rreg1", 64'(rf_rreg1), 64'd0);
        chk("rst_rf_rreg2", 64'(rf_rreg2), 64'd0);
        chk("rst_wb_ready", 64'(wb_ready), 64'd1);
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data1", 64'(rsp_data1), 64'd0);

        // Table: write then read, checking the write pulse count and register.
        for (int i = 0; i < 5; i++) begin
            c0 = wr_cnt;
            do_write(vecs[i].wreg, vecs[i].wdata);
            do_read(vecs[i].r1, vecs[i].r2, vecs[i].e1, vecs[i].e2);
            chk("wr_pulses", 64'(wr_cnt - c0), 64'((vecs[i].wreg != '0) ? 1 : 0));
            if (vecs[i].wreg != '0) chk("wr_regnum", 64'(last_wr_reg), 64'(vecs[i].wreg));
        end

        // Same-cycle read and write of r3: the read sees the old value.
        do_write(5'd3, 32'h10);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", 64'(n < 50), 64'd1);
        rsp_ready = 1'b1;
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h77;
        rd_valid = 1'b1; rd_reg1 = 5'd3; rd_reg2 = 5'd3;
        chk("same_wb_ready", 64'(wb_ready), 64'd1);
        chk("same_rd_ready", 64'(rd_ready), 64'd1);
        @(posedge clk); #1;
        wb_valid = 1'b0; rd_valid = 1'b0;
        finish_read(5'd3, 5'd3, 32'h10, 32'h10);
        do_read(5'd3, 5'd3, 32'h77, 32'h77);

        // Stalled response while four writes fill the FIFO.
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_reg1 = 5'd5; rd_reg2 = 5'd7;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("hold_rsp_arrive", 64'(rsp_valid), 64'd1);
        c0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                wb_valid = 1'b1; wb_reg = AW'(i + 1); wb_data = DW'(32'h11 * (i + 1));
            end else begin
                wb_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_data1", 64'(rsp_data1), 64'h1);
            chk("hold_rsp_data2", 64'(rsp_data2), 64'h1234_5678);
            chk("hold_rd_ready", 64'(rd_ready), 64'd0);
            $display("hold cycle %0d: wb_ready=%0b", i, wb_ready);
        end
        wb_valid = 1'b0;
        chk("full_wb_ready", 64'(wb_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        do_read(5'd1, 5'd4, 32'h11, 32'h44);
        chk("drain_pulses", 64'(wr_cnt - c0), 64'd4);

        // Reset asserted while a write is on the port; the queue is discarded.
        do_write(5'd9, 32'h99);
        wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'hAA;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("pre_rst_enwr", 64'(rf_enwr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_enwr", 64'(rf_enwr), 64'd0);
        chk("async_rst_wb_ready", 64'(wb_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("post_rst_enwr", 64'(rf_enwr), 64'd0);
        do_read(5'd10, 5'd9, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
